hazard_forward_unit: RTL and testbench

- Generates the 2-bit operand-forwarding selects consumed by the EX-stage forwarding muxes of the 8-bit pipelined core.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Keeps its own shadow copy of the destination and control fields for the EX, MEM and WB stages, advancing it in lockstep with the datapath pipeline registers.
- Sits between the ID stage (source of its inputs) and the EX-stage operand muxes (consumers of forward_a/forward_b).

---
 rtl/hazard_forward_unit.sv | 137 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Operand-forwarding select and load-use stall generator for the 8-bit core.
// Holds a shadow copy of the EX/MEM/WB destination and control fields that
// advances in lockstep with the datapath pipeline registers.
module hazard_forward_unit #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    // EX shadow
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              ex_use1;
    logic              ex_use2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_we;
    logic              ex_ld;
    // MEM shadow
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_we;
    // WB shadow
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_we;

    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;
    logic     load_use;

    // Operand A select: the MEM-stage writer is newer than WB, so it wins.
    always_comb begin
        fwd_a_sel = FWD_RF;
        if (ex_valid && ex_use1) begin
            if (mem_valid && mem_we && (mem_rd == ex_rs1)) begin
                fwd_a_sel = FWD_EXMEM;
            end else if (wb_valid && wb_we && (wb_rd == ex_rs1)) begin
                fwd_a_sel = FWD_MEMWB;
            end
        end
    end

    // Operand B select, same priority rule as operand A.
    always_comb begin
        fwd_b_sel = FWD_RF;
        if (ex_valid && ex_use2) begin
            if (mem_valid && mem_we && (mem_rd == ex_rs2)) begin
                fwd_b_sel = FWD_EXMEM;
            end else if (wb_valid && wb_we && (wb_rd == ex_rs2)) begin
                fwd_b_sel = FWD_MEMWB;
            end
        end
    end

    // Load in EX whose result the ID instruction needs; a squashed ID
    // instruction never needs to wait.
    always_comb begin
        load_use = id_valid && ex_valid && ex_ld && ex_we &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
        stall    = load_use && !flush;
    end

    assign forward_a = fwd_a_sel;
    assign forward_b = fwd_b_sel;

    // Shadow pipeline advance; EX takes a bubble on flush or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_use1   <= 1'b0;
            ex_use2   <= 1'b0;
            ex_rd     <= '0;
            ex_we     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_we    <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_we     <= 1'b0;
        end else begin
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_we    <= ex_we;
            wb_valid  <= mem_valid;
            wb_rd     <= mem_rd;
            wb_we     <= mem_we;
            if (flush || stall) begin
                ex_valid <= 1'b0;
            end else begin
                ex_valid <= id_valid;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
                ex_use1  <= id_use_rs1;
                ex_use2  <= id_use_rs2;
                ex_rd    <= id_rd;
                ex_we    <= id_reg_write;
                ex_ld    <= id_mem_read;
            end
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: an instruction-level pipeline model
// is checked every falling edge, plus literal expectations per scenario.
module tb_hazard_forward_unit;

    typedef struct packed {
        logic       valid;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       use1;
        logic       use2;
        logic [2:0] rd;
        logic       we;
        logic       ld;
    } instr_t;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [2:0] id_rs1;
    logic [2:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [2:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] forward_a;
    logic [1:0] forward_b;
    logic       stall;
    logic [7:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_forward_unit #(.REG_AW(3), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
    instr_t pipe [3];
    int     m_cnt;
    logic   m_stalled;

    function automatic instr_t id_instr();
        instr_t i;
        i.valid = id_valid;
        i.rs1   = id_rs1;
        i.rs2   = id_rs2;
        i.use1  = id_use_rs1;
        i.use2  = id_use_rs2;
        i.rd    = id_rd;
        i.we    = id_reg_write;
        i.ld    = id_mem_read;
        return i;
    endfunction

    // Youngest older instruction writing the source supplies the value:
    // one stage ahead is the EX/MEM result (01), two stages is MEM/WB (10).
    function automatic logic [1:0] exp_fwd(input logic use_src, input logic [2:0] src);
        if (!pipe[0].valid || !use_src) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].valid && pipe[k].we && pipe[k].rd == src) return 2'(k);
        end
        return 2'b00;
    endfunction

    function automatic logic exp_stall();
        instr_t i;
        i = id_instr();
        if (flush || !i.valid) return 1'b0;
        if (!(pipe[0].valid && pipe[0].ld && pipe[0].we)) return 1'b0;
        return (i.use1 && i.rs1 == pipe[0].rd) || (i.use2 && i.rs2 == pipe[0].rd);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) pipe[k] <= '0;
            m_cnt     <= 0;
            m_stalled <= 1'b0;
        end else begin
            logic s;
            s = exp_stall();
            m_stalled <= s;
            if (s && m_cnt < 255) m_cnt <= m_cnt + 1;
            pipe[2] <= pipe[1];
            pipe[1] <= pipe[0];
            if (flush || s) pipe[0] <= '0;
            else            pipe[0] <= id_instr();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("model_forward_a", 32'(forward_a), 32'(exp_fwd(pipe[0].use1, pipe[0].rs1)));
        chk("model_forward_b", 32'(forward_b), 32'(exp_fwd(pipe[0].use2, pipe[0].rs2)));
        chk("model_stall", 32'(stall), 32'(exp_stall()));
        chk("model_stall_count", 32'(stall_count), 32'(m_cnt));
    end

    // ---------------- stimulus helpers
    function automatic instr_t mk(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                                  input logic u1, input logic u2, input logic [2:0] rd,
                                  input logic we, input logic ld);
        instr_t i;
        i.valid = v; i.rs1 = rs1; i.rs2 = rs2; i.use1 = u1; i.use2 = u2;
        i.rd = rd; i.we = we; i.ld = ld;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        id_valid     = i.valid;
        id_rs1       = i.rs1;
        id_rs2       = i.rs2;
        id_use_rs1   = i.use1;
        id_use_rs2   = i.use2;
        id_rd        = i.rd;
        id_reg_write = i.we;
        id_mem_read  = i.ld;
    endtask

    // Present an instruction in ID and hold it until it has entered EX.
    task automatic issue(input instr_t i);
        drive(i);
        @(posedge clk); #1;
        for (int r = 0; r < 3 && m_stalled; r++) begin
            @(posedge clk); #1;
        end
        if (m_stalled) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: stall still %0b after retries", m_stalled);
        end
    endtask

    task automatic idle(input int n);
        drive('0);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive('0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    instr_t nop, add3, sub3, add2, or2, ld5, add55, ld4, dep4, ld1, use1;

    initial begin
        nop   = '0;
        add3  = mk(1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        sub3  = mk(1'b1, 3'd3, 3'd4, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
        add2  = mk(1'b1, 3'd1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
        or2   = mk(1'b1, 3'd5, 3'd2, 1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
        ld5   = mk(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1);
        add55 = mk(1'b1, 3'd5, 3'd5, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
        ld4   = mk(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1);
        dep4  = mk(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        ld1   = mk(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
        use1  = mk(1'b1, 3'd1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);

        // Reset held three cycles with random ID inputs.
        rst_n = 1'b1;
        flush = 1'b0;
        drive('0);
        #1 rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(instr_t'($urandom));
            flush = 1'($urandom_range(1));
            @(posedge clk); #1;
        end
        chk("reset_forward_a", 32'(forward_a), 32'h0);
        chk("reset_forward_b", 32'(forward_b), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_stall_count", 32'(stall_count), 32'h0);
        flush = 1'b0;
        drive(nop);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_forward_a", 32'(forward_a), 32'h0);
        chk("first_cycle_forward_b", 32'(forward_b), 32'h0);
        chk("first_cycle_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;

        // EX/MEM forward on operand A.
        issue(add3);
        issue(sub3);
        chk("exmem_forward_a", 32'(forward_a), 32'h1);
        chk("exmem_forward_b", 32'(forward_b), 32'h0);
        chk("exmem_stall", 32'(stall), 32'h0);
        idle(3);

        // MEM/WB forward on operand B with an empty slot between.
        issue(add2);
        issue(nop);
        issue(or2);
        chk("memwb_forward_b", 32'(forward_b), 32'h2);
        chk("memwb_forward_a", 32'(forward_a), 32'h0);
        idle(3);

        // Back-to-back writers of r2: the newer one in MEM wins.
        issue(add2);
        issue(add2);
        issue(or2);
        chk("priority_forward_b", 32'(forward_b), 32'h1);
        idle(3);

        // Load-use: one stall, one bubble, then WB forwarding on both operands.
        pulse_reset();
        issue(ld5);
        drive(add55);
        #1 chk("loaduse_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        chk("loaduse_stall_released", 32'(stall), 32'h0);
        chk("loaduse_bubble_fa", 32'(forward_a), 32'h0);
        chk("loaduse_bubble_fb", 32'(forward_b), 32'h0);
        @(posedge clk); #1;
        chk("loaduse_forward_a", 32'(forward_a), 32'h2);
        chk("loaduse_forward_b", 32'(forward_b), 32'h2);
        chk("loaduse_stall_count", 32'(stall_count), 32'h1);
        idle(3);

        // Flush overrides the load-use stall; the dependent is squashed.
        issue(ld4);
        drive(dep4);
        flush = 1'b1;
        #1 chk("flush_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(nop);
        #1;
        chk("flush_bubble_fa", 32'(forward_a), 32'h0);
        chk("flush_bubble_fb", 32'(forward_b), 32'h0);
        chk("flush_stall_next", 32'(stall), 32'h0);
        chk("flush_count_held", 32'(stall_count), 32'h1);
        idle(3);

        // 260 load-use stalls on top of the existing one: count saturates.
        for (int n = 0; n < 260; n++) begin
            issue(ld1);
            issue(use1);
        end
        chk("saturated_count", 32'(stall_count), 32'hFF);
        chk("pre_reset_forward_a", 32'(forward_a), 32'h2);

        // Asynchronous reset mid-cycle clears everything without a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_count", 32'(stall_count), 32'h0);
        chk("async_reset_forward_a", 32'(forward_a), 32'h0);
        chk("async_reset_forward_b", 32'(forward_b), 32'h0);
        chk("async_reset_stall", 32'(stall), 32'h0);
        drive(nop);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
